// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle MIPS-subset controller. A six-state FSM
//             (IF/DCD/EXE/MEM/WB/BR) sequences each instruction and
//             decodes it into datapath control strobes. It also counts
//             retired instructions.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             instr[31:0]        - instruction register contents
//             zero               - ALU equality flag (used in BR)
//             irwr, pcwr, rfwr,
//             dmwr               - write enables
//             npc_op, regdst,
//             alusrc, aluop,
//             extop, wbsel       - datapath selects
//             state[2:0]         - current FSM state
//             retired[31:0]      - completed-instruction count
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        irwr,
  output logic        pcwr,
  output logic [1:0]  npc_op,
  output logic        rfwr,
  output logic [1:0]  regdst,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [1:0]  extop,
  output logic        dmwr,
  output logic [1:0]  wbsel,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_DCD = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_BR  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;

  // --------------------------------------------------------------------------
  // Instruction decode
  // --------------------------------------------------------------------------
  logic [5:0] op;
  logic [5:0] funct;
  logic       is_rtype;
  logic       is_addu, is_subu, is_jr;
  logic       is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
  logic       is_alu_group;   // instructions that go through EXE then WB
  logic       unused_instr_bits;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign is_rtype = (op == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_lui   = (op == 6'b001111);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_alu_group = is_addu || is_subu || is_ori || is_lui;

  // Register fields are consumed by the datapath, not by the controller.
  assign unused_instr_bits = ^instr[25:6];

  // --------------------------------------------------------------------------
  // State and retire-counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  // ALU controls are shared by EXE and WB so the ALU result stays stable
  // while it is being written back.
  logic [1:0] alu_aluop;
  logic       alu_alusrc;
  logic [1:0] alu_extop;

  always_comb begin
    alu_aluop  = 2'b00;
    alu_alusrc = 1'b0;
    alu_extop  = 2'b00;
    if (is_subu) begin
      alu_aluop = 2'b01;
    end else if (is_ori) begin
      alu_aluop  = 2'b10;
      alu_alusrc = 1'b1;
      alu_extop  = 2'b00;
    end else if (is_lui) begin
      alu_aluop  = 2'b10;
      alu_alusrc = 1'b1;
      alu_extop  = 2'b10;
    end else if (is_lw || is_sw) begin
      alu_aluop  = 2'b00;
      alu_alusrc = 1'b1;
      alu_extop  = 2'b01;
    end
  end

  logic irwr_raw, pcwr_raw, rfwr_raw, dmwr_raw;

  always_comb begin
    state_d  = S_IF;
    irwr_raw = 1'b0;
    pcwr_raw = 1'b0;
    rfwr_raw = 1'b0;
    dmwr_raw = 1'b0;
    npc_op   = 2'b00;
    regdst   = 2'b00;
    alusrc   = 1'b0;
    aluop    = 2'b00;
    extop    = 2'b00;
    wbsel    = 2'b00;

    case (state_q)
      S_IF: begin
        irwr_raw = 1'b1;
        pcwr_raw = 1'b1;
        npc_op   = 2'b00;
        state_d  = S_DCD;
      end

      S_DCD: begin
        if (is_j) begin
          pcwr_raw = 1'b1;
          npc_op   = 2'b10;
          state_d  = S_IF;
        end else if (is_jal) begin
          pcwr_raw = 1'b1;
          npc_op   = 2'b10;
          rfwr_raw = 1'b1;
          regdst   = 2'b10;
          wbsel    = 2'b10;
          state_d  = S_IF;
        end else if (is_jr) begin
          pcwr_raw = 1'b1;
          npc_op   = 2'b11;
          state_d  = S_IF;
        end else if (is_beq) begin
          state_d = S_BR;
        end else if (is_alu_group || is_lw || is_sw) begin
          state_d = S_EXE;
        end else begin
          state_d = S_IF;   // unknown: dropped, but still retired
        end
      end

      S_EXE: begin
        aluop  = alu_aluop;
        alusrc = alu_alusrc;
        extop  = alu_extop;
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_alu_group) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end

      S_MEM: begin
        if (is_sw) begin
          dmwr_raw = 1'b1;
          state_d  = S_IF;
        end else if (is_lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end

      S_WB: begin
        rfwr_raw = 1'b1;
        aluop    = alu_aluop;
        alusrc   = alu_alusrc;
        extop    = alu_extop;
        if (is_rtype) begin
          regdst = 2'b01;
          wbsel  = 2'b00;
        end else if (is_lw) begin
          regdst = 2'b00;
          wbsel  = 2'b01;
        end else begin
          regdst = 2'b00;
          wbsel  = 2'b00;
        end
        state_d = S_IF;
      end

      S_BR: begin
        aluop    = 2'b01;
        alusrc   = 1'b0;
        npc_op   = 2'b01;
        pcwr_raw = zero;
        state_d  = S_IF;
      end

      default: begin
        // Encodings 6 and 7: drive nothing and recover to fetch.
        state_d = S_IF;
      end
    endcase
  end

  // An instruction retires on the edge that returns the FSM to fetch.
  always_comb begin
    retired_d = retired_q;
    if ((state_d == S_IF) && (state_q != S_IF)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  // Write enables are gated by reset so no stray write occurs while the
  // FSM is being forced back to fetch.
  assign irwr = irwr_raw & ~rst;
  assign pcwr = pcwr_raw & ~rst;
  assign rfwr = rfwr_raw & ~rst;
  assign dmwr = dmwr_raw & ~rst;

  assign state   = state_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Directed self-checking bench for mc_ctrl. Each instruction is
//             walked through its states cycle by cycle and the full control
//             vector, state and retire count are compared with hand-derived
//             values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        irwr, pcwr, rfwr, alusrc, dmwr;
  logic [1:0]  npc_op, regdst, aluop, extop, wbsel;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_total;
  int n_pass;

  mc_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .zero    (zero),
    .irwr    (irwr),
    .pcwr    (pcwr),
    .npc_op  (npc_op),
    .rfwr    (rfwr),
    .regdst  (regdst),
    .alusrc  (alusrc),
    .aluop   (aluop),
    .extop   (extop),
    .dmwr    (dmwr),
    .wbsel   (wbsel),
    .state   (state),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector: {irwr,pcwr,npc_op,rfwr,regdst,alusrc,aluop,extop,dmwr,wbsel}
  function automatic logic [14:0] ctl(
    input logic       i_irwr,
    input logic       i_pcwr,
    input logic [1:0] i_npc,
    input logic       i_rfwr,
    input logic [1:0] i_regdst,
    input logic       i_alusrc,
    input logic [1:0] i_aluop,
    input logic [1:0] i_extop,
    input logic       i_dmwr,
    input logic [1:0] i_wbsel
  );
    return {i_irwr, i_pcwr, i_npc, i_rfwr, i_regdst, i_alusrc,
            i_aluop, i_extop, i_dmwr, i_wbsel};
  endfunction

  logic [14:0] c_none;
  logic [14:0] c_if;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Compare the current state and control vector.
  task automatic expect_cycle(input string tag, input logic [2:0] exp_state,
                              input logic [14:0] exp_ctl);
    #1;
    check({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
    check({tag, ".ctl"},
          {17'd0, irwr, pcwr, npc_op, rfwr, regdst, alusrc, aluop, extop,
           dmwr, wbsel},
          {17'd0, exp_ctl});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    c_none  = 15'd0;
    c_if    = ctl(1, 1, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00);
    rst     = 1'b1;
    instr   = 32'h0000_0000;
    zero    = 1'b0;

    // ---- reset: state IF, counter clear, enables masked --------------------
    step();
    step();
    expect_cycle("reset", 3'd0, c_none);
    check("reset.retired", retired, 32'd0);

    // ---- lw --------------------------------------------------------------
    rst   = 1'b0;
    instr = 32'h8C22_0004;
    expect_cycle("lw.if", 3'd0, c_if);
    step(); expect_cycle("lw.dcd", 3'd1, c_none);
    step(); expect_cycle("lw.exe", 3'd2, ctl(0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00));
    step(); expect_cycle("lw.mem", 3'd3, c_none);
    step(); expect_cycle("lw.wb",  3'd4, ctl(0, 0, 2'b00, 1, 2'b00, 1, 2'b00, 2'b01, 0, 2'b01));
    step(); expect_cycle("lw.end", 3'd0, c_if);
    check("lw.retired", retired, 32'd1);

    // ---- sw --------------------------------------------------------------
    instr = 32'hAC22_0004;
    step(); expect_cycle("sw.dcd", 3'd1, c_none);
    step(); expect_cycle("sw.exe", 3'd2, ctl(0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00));
    step(); expect_cycle("sw.mem", 3'd3, ctl(0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00));
    step(); expect_cycle("sw.end", 3'd0, c_if);
    check("sw.retired", retired, 32'd2);

    // ---- beq taken / not taken -------------------------------------------
    instr = 32'h1022_0003;
    zero  = 1'b1;
    step(); expect_cycle("beq1.dcd", 3'd1, c_none);
    step(); expect_cycle("beq1.br",  3'd5, ctl(0, 1, 2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00));
    step(); expect_cycle("beq1.end", 3'd0, c_if);
    check("beq1.retired", retired, 32'd3);
    zero = 1'b0;
    step(); expect_cycle("beq0.dcd", 3'd1, c_none);
    step(); expect_cycle("beq0.br",  3'd5, ctl(0, 0, 2'b01, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00));
    step(); expect_cycle("beq0.end", 3'd0, c_if);
    check("beq0.retired", retired, 32'd4);

    // ---- jumps -----------------------------------------------------------
    instr = 32'h0C00_0010;   // jal
    step(); expect_cycle("jal.dcd", 3'd1, ctl(0, 1, 2'b10, 1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b10));
    step(); expect_cycle("jal.end", 3'd0, c_if);
    check("jal.retired", retired, 32'd5);
    instr = 32'h0800_0010;   // j
    step(); expect_cycle("j.dcd", 3'd1, ctl(0, 1, 2'b10, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
    step(); expect_cycle("j.end", 3'd0, c_if);
    instr = 32'h03E0_0008;   // jr $31
    step(); expect_cycle("jr.dcd", 3'd1, ctl(0, 1, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00));
    step(); expect_cycle("jr.end", 3'd0, c_if);
    check("jr.retired", retired, 32'd7);

    // ---- unknown op and unknown R-type funct -----------------------------
    instr = 32'hFC00_0000;
    step(); expect_cycle("unk.dcd", 3'd1, c_none);
    step(); expect_cycle("unk.end", 3'd0, c_if);
    check("unk.retired", retired, 32'd8);
    instr = 32'h0000_0000;   // sll: not supported
    step(); expect_cycle("unkf.dcd", 3'd1, c_none);
    step(); expect_cycle("unkf.end", 3'd0, c_if);
    check("unkf.retired", retired, 32'd9);

    // ---- ALU group -------------------------------------------------------
    instr = 32'h0022_1821;   // addu
    step(); expect_cycle("addu.dcd", 3'd1, c_none);
    step(); expect_cycle("addu.exe", 3'd2, c_none);
    step(); expect_cycle("addu.wb",  3'd4, ctl(0, 0, 2'b00, 1, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00));
    step(); expect_cycle("addu.end", 3'd0, c_if);
    instr = 32'h0022_1823;   // subu
    step(); expect_cycle("subu.dcd", 3'd1, c_none);
    step(); expect_cycle("subu.exe", 3'd2, ctl(0, 0, 2'b00, 0, 2'b00, 0, 2'b01, 2'b00, 0, 2'b00));
    step(); expect_cycle("subu.wb",  3'd4, ctl(0, 0, 2'b00, 1, 2'b01, 0, 2'b01, 2'b00, 0, 2'b00));
    step(); expect_cycle("subu.end", 3'd0, c_if);
    instr = 32'h3422_0005;   // ori
    step(); expect_cycle("ori.dcd", 3'd1, c_none);
    step(); expect_cycle("ori.exe", 3'd2, ctl(0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00));
    step(); expect_cycle("ori.wb",  3'd4, ctl(0, 0, 2'b00, 1, 2'b00, 1, 2'b10, 2'b00, 0, 2'b00));
    step(); expect_cycle("ori.end", 3'd0, c_if);
    instr = 32'h3C02_0005;   // lui
    step(); expect_cycle("lui.dcd", 3'd1, c_none);
    step(); expect_cycle("lui.exe", 3'd2, ctl(0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b10, 0, 2'b00));
    step(); expect_cycle("lui.wb",  3'd4, ctl(0, 0, 2'b00, 1, 2'b00, 1, 2'b10, 2'b10, 0, 2'b00));
    step(); expect_cycle("lui.end", 3'd0, c_if);
    check("alu.retired", retired, 32'd13);

    // ---- reset during addu EXE -------------------------------------------
    instr = 32'h0022_1821;
    step(); expect_cycle("rstx.dcd", 3'd1, c_none);
    step(); expect_cycle("rstx.exe", 3'd2, c_none);
    rst = 1'b1;
    step(); expect_cycle("rstx.rst", 3'd0, c_none);
    check("rstx.retired", retired, 32'd0);
    rst = 1'b0;
    expect_cycle("rstx.if", 3'd0, c_if);
    step(); expect_cycle("rstx.dcd2", 3'd1, c_none);
    check("rstx.retired2", retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
